// File: rtl/sort_stream_ctrl_if.sv
// Stream, status and network lanes of sort_stream_ctrl.
// master = surrounding logic (source, sink, network); slave = the controller.
interface sort_stream_ctrl_if #(
    parameter int N = 10,
    parameter int W = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           busy;
    logic [N*W-1:0] net_in;
    logic [N*W-1:0] net_out;

    modport master (
        output in_valid, in_data, in_last, out_ready, net_out,
        input  in_ready, out_valid, out_data, out_last, busy, net_in
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready, net_out,
        output in_ready, out_valid, out_data, out_last, busy, net_in
    );
endinterface

// File: rtl/sort_stream_ctrl.sv
// Streams a frame of N words through an external N-lane ascending sort network.
// Optional `define SORT_PARTIAL_EN: in_last ends a frame early, unused lanes padded with all-ones.
module sort_stream_ctrl #(
    parameter int N       = 10,
    parameter int W       = 32,
    parameter int NET_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    sort_stream_ctrl_if.slave io_bus
);
    localparam int CW = $clog2(N + 1);
    localparam int TW = (NET_LAT > 0) ? $clog2(NET_LAT + 1) : 1;

    typedef enum logic [1:0] {S_LOAD, S_WAIT, S_DRAIN} state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [W-1:0]   r_ibuf [N];
    logic [W-1:0]   r_obuf [N];
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  r_idx;
    logic [TW-1:0]  r_timer;
    logic           r_in_ready;

    logic           w_accept;
    logic           w_frame_end;
    logic           w_timer_done;
    logic           w_xfer;
    logic           w_out_last;
    logic [W-1:0]   w_out_data;
    logic [N*W-1:0] w_net_in;

    always_comb begin
        w_accept     = io_bus.in_valid && r_in_ready && (r_state == S_LOAD);
        w_frame_end  = (r_cnt == CW'(N - 1));
`ifdef SORT_PARTIAL_EN
        w_frame_end  = w_frame_end || io_bus.in_last;
`endif
        w_timer_done = (r_timer == TW'(NET_LAT));
        w_out_last   = (r_state == S_DRAIN) && (r_idx == r_cnt - CW'(1));
        w_xfer       = (r_state == S_DRAIN) && io_bus.out_ready;
        w_out_data   = (r_state == S_DRAIN) ? r_obuf[r_idx] : '0;

        w_next_state = r_state;
        case (r_state)
            S_LOAD:  if (w_accept && w_frame_end) w_next_state = S_WAIT;
            S_WAIT:  if (w_timer_done)            w_next_state = S_DRAIN;
            S_DRAIN: if (w_xfer && w_out_last)    w_next_state = S_LOAD;
            default:                              w_next_state = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            // Registered so the ready flag first appears one edge after reset release.
            r_in_ready <= (w_next_state == S_LOAD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N; k++) begin
                r_ibuf[k] <= '0;
                r_obuf[k] <= '0;
            end
            r_cnt   <= '0;
            r_idx   <= '0;
            r_timer <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        for (int unsigned k = 0; k < N; k++) begin
                            if (CW'(k) == r_cnt) begin
                                r_ibuf[k] <= io_bus.in_data;
                            end
`ifdef SORT_PARTIAL_EN
                            else if (io_bus.in_last && (CW'(k) > r_cnt)) begin
                                r_ibuf[k] <= '1;
                            end
`endif
                        end
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (w_timer_done) begin
                        for (int unsigned k = 0; k < N; k++) begin
                            r_obuf[k] <= io_bus.net_out[k*W +: W];
                        end
                        r_idx   <= '0;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_xfer) begin
                        r_idx <= r_idx + CW'(1);
                        if (w_out_last) begin
                            r_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_net_in = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_net_in[k*W +: W] = r_ibuf[k];
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = (r_state == S_DRAIN);
    assign io_bus.out_data  = w_out_data;
    assign io_bus.out_last  = w_out_last;
    assign io_bus.busy      = (r_state != S_LOAD);
    assign io_bus.net_in    = w_net_in;
endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Bench for sort_stream_ctrl: one DUT on a combinational network (NET_LAT=0),
// one on a two-stage delayed network (NET_LAT=2); expected order from a sorted queue.
module tb_sort_stream_ctrl;
    localparam int N = 10;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   t_acc = 0;

    logic         sel      = 1'b0;
    logic         t_valid  = 1'b0;
    logic         t_last   = 1'b0;
    logic         t_oready = 1'b0;
    logic [W-1:0] t_data   = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sort_stream_ctrl_if #(.N(N), .W(W)) u_if0 ();
    sort_stream_ctrl_if #(.N(N), .W(W)) u_if1 ();

    sort_stream_ctrl #(.N(N), .W(W), .NET_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .io_bus(u_if0.slave));
    sort_stream_ctrl #(.N(N), .W(W), .NET_LAT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .io_bus(u_if1.slave));

    assign u_if0.in_valid  = t_valid & ~sel;
    assign u_if0.in_data   = t_data;
    assign u_if0.in_last   = t_last;
    assign u_if0.out_ready = t_oready & ~sel;
    assign u_if1.in_valid  = t_valid & sel;
    assign u_if1.in_data   = t_data;
    assign u_if1.in_last   = t_last;
    assign u_if1.out_ready = t_oready & sel;

    logic         o_valid, o_last, o_in_ready, o_busy;
    logic [W-1:0] o_data;
    assign o_valid    = sel ? u_if1.out_valid : u_if0.out_valid;
    assign o_last     = sel ? u_if1.out_last  : u_if0.out_last;
    assign o_data     = sel ? u_if1.out_data  : u_if0.out_data;
    assign o_in_ready = sel ? u_if1.in_ready  : u_if0.in_ready;
    assign o_busy     = sel ? u_if1.busy      : u_if0.busy;

    // Attached network: ascending sort of the lanes (insertion sort).
    function automatic logic [N*W-1:0] net_sort(input logic [N*W-1:0] v);
        logic [W-1:0]   a [N];
        logic [W-1:0]   t;
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) a[i] = v[i*W +: W];
        for (int i = 1; i < N; i++)
            for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
        return r;
    endfunction

    logic [N*W-1:0] d1, d2;
    assign u_if0.net_out = net_sort(u_if0.net_in);
    always @(posedge clk) begin
        d1 <= net_sort(u_if1.net_in);
        d2 <= d1;
    end
    assign u_if1.net_out = d2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] q[$], input bit last_end, input int gap_max);
        for (int i = 0; i < q.size(); i++) begin
            int  g;
            int  guard;
            bit  acc;
            g = $urandom_range(gap_max, 0);
            repeat (g) begin t_valid = 1'b0; @(posedge clk); #1; end
            t_valid = 1'b1;
            t_data  = q[i];
            t_last  = last_end && (i == q.size() - 1);
            acc = 1'b0; guard = 0;
            while (!acc && guard < 50) begin
                acc = o_in_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!acc) begin
                total++; bad++;
                $error("FAIL send_timeout observed=no_accept expected=accept word=%0d", i);
            end
        end
        t_acc   = cyc;
        t_valid = 1'b0;
        t_last  = 1'b0;
    endtask

    // mode: 0 ready held high, 1 toggles 1/0, 2 random. Returns early after nstop words.
    task automatic recv(input logic [W-1:0] exp[$], input int lat, input int mode, input int nstop);
        int guard;
        int k;
        bit rdy;
        chk("busy_after_last_accept", o_busy, 1);
        chk("in_ready_after_last_accept", o_in_ready, 0);
        guard = 0;
        while (!o_valid && guard < 50) begin @(posedge clk); #1; guard++; end
        chk("first_out_latency", cyc - t_acc, 1 + lat);
        k = 0; guard = 0;
        while (k < nstop && guard < 500) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (guard % 2 == 0);
                default: rdy = 1'($urandom_range(1, 0));
            endcase
            t_oready = rdy;
            chk("out_valid", o_valid, 1);
            chk("out_data", o_data, exp[k]);
            chk("out_last", o_last, (k == exp.size() - 1));
            chk("in_ready_drain", o_in_ready, 0);
            @(posedge clk); #1;
            guard++;
            if (rdy) k++;
        end
        t_oready = 1'b0;
        if (k < nstop) begin
            total++; bad++;
            $error("FAIL drain_timeout observed=%0d expected=%0d", k, nstop);
        end
        if (nstop == exp.size()) begin
            chk("out_valid_after_frame", o_valid, 0);
            chk("busy_after_frame", o_busy, 0);
            chk("in_ready_after_frame", o_in_ready, 1);
        end
    endtask

    initial begin
        #2000000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] q[$];
        logic [W-1:0] q2[$];
        logic [W-1:0] e[$];
        logic [W-1:0] dup_in [N];
        logic [W-1:0] dup_ex [N];
        dup_in = '{32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 32'd1, 32'd1, 32'd0, 32'd7, 32'd5};
        dup_ex = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd5, 32'd5, 32'd5, 32'd5, 32'd7, 32'hFFFF_FFFF};

        // Reset values
        #1;
        chk("rst_out_valid", o_valid, 0);
        chk("rst_out_last", o_last, 0);
        chk("rst_out_data", o_data, 0);
        chk("rst_busy", o_busy, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", o_in_ready, 1);

        // Descending full frame, continuous drain
        q.delete();
        for (int i = 0; i < N; i++) q.push_back(W'(N - 1 - i));
        send(q, 1'b0, 0);
        e = q; e.sort();
        recv(e, 0, 0, N);

        // Same frame under toggling back-pressure
        send(q, 1'b0, 0);
        recv(e, 0, 1, N);

        // Duplicates and extremes
        q.delete(); e.delete();
        for (int i = 0; i < N; i++) begin q.push_back(dup_in[i]); e.push_back(dup_ex[i]); end
        send(q, 1'b0, 1);
        recv(e, 0, 2, N);

        // Random frames, alternating wide values and narrow (tie-heavy) values
        for (int f = 0; f < 4; f++) begin
            q.delete();
            for (int i = 0; i < N; i++)
                q.push_back((f % 2 == 1) ? W'($urandom_range(7, 0)) : W'($urandom));
            send(q, 1'b0, 2);
            e = q; e.sort();
            recv(e, 0, 2, N);
        end

        // Reset in DRAIN with idx=3
        q.delete();
        for (int i = 0; i < N; i++) q.push_back(W'($urandom));
        send(q, 1'b0, 0);
        e = q; e.sort();
        recv(e, 0, 0, 3);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", o_valid, 0);
        chk("midreset_out_data", o_data, 0);
        chk("midreset_busy", o_busy, 0);
        @(posedge clk); #1;
        chk("midreset_held_out_valid", o_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midreset_in_ready", o_in_ready, 1);
        repeat (3) begin
            chk("midreset_no_partial_out", o_valid, 0);
            @(posedge clk); #1;
        end
        q.delete();
        for (int i = 0; i < N; i++) q.push_back(W'($urandom));
        send(q, 1'b0, 1);
        e = q; e.sort();
        recv(e, 0, 0, N);

        // Early frame end via in_last
        q = {32'd7, 32'hFFFF_FFFF, 32'd2};
`ifdef SORT_PARTIAL_EN
        send(q, 1'b1, 0);
        e = {32'd2, 32'd7, 32'hFFFF_FFFF};
        recv(e, 0, 0, 3);
`else
        send(q, 1'b1, 0);
        repeat (3) begin
            chk("in_last_ignored_in_ready", o_in_ready, 1);
            chk("in_last_ignored_busy", o_busy, 0);
            chk("in_last_ignored_valid", o_valid, 0);
            @(posedge clk); #1;
        end
        q2.delete();
        for (int i = 0; i < N - 3; i++) q2.push_back(W'($urandom));
        send(q2, 1'b0, 1);
        e = {q, q2}; e.sort();
        recv(e, 0, 2, N);
`endif

        // NET_LAT=2 instance
        sel = 1'b1;
        #1;
        q.delete();
        for (int i = 0; i < N; i++) q.push_back(W'(N - 1 - i));
        send(q, 1'b0, 0);
        e = q; e.sort();
        recv(e, 2, 0, N);
        q.delete();
        for (int i = 0; i < N; i++) q.push_back(W'($urandom_range(15, 0)));
        send(q, 1'b0, 2);
        e = q; e.sort();
        recv(e, 2, 2, N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
